sound_dac_ds: RTL and testbench
===============================

// Module: sound_dac_ds
// PURPOSE
//  Final audio output stage, downstream of the external/cartridge sound mixers.
//  Converts the mixed signed PCM sample into a 1-bit first-order delta-sigma
//  stream that drives an external RC filter.
//  Provides pop-free ramp-up on enable, ramp-down on disable, and a mute that
//  outputs midscale silence.
// PARAMETERS
//  WIDTH      16  sample width; signed two's-complement input
//  DIV        1   modulator tick every DIV clocks (>=1)
//  RAMP_STEP  16  level increment/decrement per tick while ramping (>=1)
// PORTS
//  CLK        in   1      system clock
//  RESET_n    in   1      synchronous reset, active-low
//  IN_DATA    in   WIDTH  signed sample from mixer
//  IN_STROBE  in   1      IN_DATA valid this cycle
//  ENABLE     in   1      1 = ramp up and run; 0 = ramp down to idle
//  MUTE       in   1      1 = midscale silence while running
//  DAC_OUT    out  1      delta-sigma bit to output pin
//  ACTIVE     out  1      1 while in RUN
// BEHAVIOUR
//  - Clock: one clock CLK. Reset: synchronous, active-low RESET_n.
//  - Reset state: state=IDLE, hold=0, level=0, acc=0, div_cnt=0,
//    DAC_OUT=0, ACTIVE=0.
//  - Sample hold: on IN_STROBE=1 (any cycle, any state), hold<=IN_DATA.
//    Only the last strobe before a tick counts.
//  - Tick: div_cnt counts 0..DIV-1; tick=1 when div_cnt==DIV-1, then wraps.
//    DIV=1 gives a tick on every clock.
//  - MID = 2^(WIDTH-1).
//  - Modulator value u (WIDTH bits unsigned):
//    - RUN, MUTE=0: u = hold with MSB inverted (offset binary).
//    - RUN, MUTE=1: u = MID.
//    - IDLE, RAMP_UP, RAMP_DOWN: u = level.
//  - Delta-sigma, on tick only:
//    - sum = {1'b0,acc} + u, computed in WIDTH+1 bits.
//    - acc <= sum[WIDTH-1:0].
//    - DAC_OUT <= sum[WIDTH].
//    - Between ticks, acc and DAC_OUT hold their values.
//    - Latency: u sampled on a tick edge; DAC_OUT valid from that edge.
//    - Ones density = u / 2^WIDTH.
//  - FSM (transitions and level updates occur on tick only; ENABLE is sampled
//    at the tick):
//    - IDLE: level=0. ENABLE=1 -> RAMP_UP.
//    - RAMP_UP:
//      - ENABLE=0 -> RAMP_DOWN, level unchanged.
//      - Else if level+RAMP_STEP >= MID -> level=MID, go to RUN.
//      - Else level += RAMP_STEP.
//    - RUN: level stays MID. ENABLE=0 -> RAMP_DOWN from MID.
//      The audio-to-midscale step at that point is accepted.
//    - RAMP_DOWN:
//      - ENABLE=1 -> RAMP_UP from current level.
//      - Else if level <= RAMP_STEP -> level=0, go to IDLE.
//      - Else level -= RAMP_STEP.
//  - ACTIVE = (state==RUN), registered along with state.
//  - Level arithmetic uses WIDTH+1 bits: no wrap, saturates at 0 and MID.
//  - MUTE toggles mid-stream: takes effect on the next tick; acc is not cleared.
//  - RESET_n=0 at any time (including mid-ramp): reset state on the next edge;
//    DAC_OUT=0 after that edge.
// TESTING
//  1. DIV=1, STEP=16, WIDTH=16; reset, then ENABLE=1.
//     -> ACTIVE=1 after exactly 2048 ticks in RAMP_UP.
//     -> Ones count per 256-clock window is non-decreasing during the ramp.
//  2. RUN, IN_DATA=0x0000 strobed -> DAC_OUT toggles 1,0,1,0...;
//     exactly 512 ones in 1024 clocks.
//  3. IN_DATA=0x7FFF -> 65535 ones in 65536 ticks.
//     IN_DATA=0x8000 -> DAC_OUT constantly 0.
//     IN_DATA=0x4000 -> exactly 3 ones in every 4 ticks.
//  4. RUN with IN_DATA=0x7FFF, MUTE=1 -> 50% pattern from the next tick.
//     Then ENABLE=0 -> ACTIVE=0 next tick; IDLE after 2048 ticks;
//     DAC_OUT stays 0 thereafter.
//  5. DIV=4:
//     -> DAC_OUT changes only on clocks where div_cnt==3.
//     -> Strobes between ticks: only the last one affects u.
//  6. Reset, ENABLE=1, then assert RESET_n=0 at tick 1000 of RAMP_UP
//     -> DAC_OUT=0, ACTIVE=0, state IDLE on the next edge.
//     Release reset with ENABLE=1 -> ramp restarts from level 0.

Source files
------------

// File: rtl/sound_dac_ds.sv
// sound_dac_ds
//   Final audio output stage. Turns the mixed signed PCM sample into a 1-bit
//   first-order delta-sigma stream for an external RC filter. Enabling ramps
//   the output up from 0 to midscale and disabling ramps it back down, so the
//   pin never jumps. MUTE substitutes midscale silence while running.
//
// Parameters
//   WIDTH      sample width (signed two's-complement input)
//   DIV        modulator tick every DIV clocks (>=1)
//   RAMP_STEP  level change per tick while ramping (>=1)
//
// Ports
//   CLK        in   system clock
//   RESET_n    in   synchronous reset, active-low
//   IN_DATA    in   signed sample from the mixer
//   IN_STROBE  in   IN_DATA valid this cycle; latched into the hold register
//   ENABLE     in   1 = ramp up and run, 0 = ramp down to idle
//   MUTE       in   1 = midscale silence while running
//   DAC_OUT    out  delta-sigma bit to the output pin
//   ACTIVE     out  1 while in RUN
//   DBG_STATE  out  current FSM state: 0 IDLE, 1 RAMP_UP, 2 RUN, 3 RAMP_DOWN
//
// Handshake: IN_DATA is captured on every clock where IN_STROBE=1; there is
// no back-pressure. Only the last strobe before a tick reaches the modulator.

module sound_dac_ds #(
   parameter int WIDTH     = 16,
   parameter int DIV       = 1,
   parameter int RAMP_STEP = 16
) (
   input  logic             CLK,
   input  logic             RESET_n,
   input  logic [WIDTH-1:0] IN_DATA,
   input  logic             IN_STROBE,
   input  logic             ENABLE,
   input  logic             MUTE,
   output logic             DAC_OUT,
   output logic             ACTIVE,
   output logic [1:0]       DBG_STATE
);

   localparam logic [1:0] S_IDLE      = 2'd0;
   localparam logic [1:0] S_RAMP_UP   = 2'd1;
   localparam logic [1:0] S_RUN       = 2'd2;
   localparam logic [1:0] S_RAMP_DOWN = 2'd3;

   localparam int            CW       = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [CW-1:0] DIV_LAST = CW'(DIV - 1);

   // Level arithmetic is one bit wider than a sample so ramping never wraps.
   localparam logic [WIDTH:0] MID  = {2'b01, {(WIDTH-1){1'b0}}};
   localparam logic [WIDTH:0] STEP = (WIDTH+1)'(RAMP_STEP);

   logic [1:0]       state_q,   state_d;
   logic [WIDTH-1:0] hold_q,    hold_d;
   logic [WIDTH:0]   level_q,   level_d;
   logic [WIDTH-1:0] acc_q,     acc_d;
   logic [CW-1:0]    div_cnt_q, div_cnt_d;
   logic             dac_q,     dac_d;
   logic             active_q,  active_d;

   logic             tick;
   logic [WIDTH-1:0] u;
   logic [WIDTH:0]   sum;
   logic [WIDTH:0]   level_up;

   assign tick     = (div_cnt_q == DIV_LAST);
   assign level_up = level_q + STEP;
   assign sum      = {1'b0, acc_q} + {1'b0, u};

   always_comb begin
      div_cnt_d = tick ? '0 : div_cnt_q + CW'(1);
      hold_d    = IN_STROBE ? IN_DATA : hold_q;

      // Running audio is converted to offset binary by flipping the sign bit.
      // Outside RUN the ramp level drives the modulator directly.
      u = level_q[WIDTH-1:0];
      if (state_q == S_RUN) begin
         if (MUTE) u = MID[WIDTH-1:0];
         else      u = {~hold_q[WIDTH-1], hold_q[WIDTH-2:0]};
      end

      acc_d = tick ? sum[WIDTH-1:0] : acc_q;
      dac_d = tick ? sum[WIDTH]     : dac_q;

      state_d = state_q;
      level_d = level_q;
      if (tick) begin
         case (state_q)
            S_IDLE: begin
               level_d = '0;
               if (ENABLE) state_d = S_RAMP_UP;
            end
            S_RAMP_UP: begin
               if (!ENABLE) begin
                  state_d = S_RAMP_DOWN;
               end else if (level_up >= MID) begin
                  level_d = MID;
                  state_d = S_RUN;
               end else begin
                  level_d = level_up;
               end
            end
            S_RUN: begin
               // Dropping from audio to the midscale ramp start is a single
               // accepted step; the ramp-down handles the rest.
               level_d = MID;
               if (!ENABLE) state_d = S_RAMP_DOWN;
            end
            S_RAMP_DOWN: begin
               if (ENABLE) begin
                  state_d = S_RAMP_UP;
               end else if (level_q <= STEP) begin
                  level_d = '0;
                  state_d = S_IDLE;
               end else begin
                  level_d = level_q - STEP;
               end
            end
         endcase
      end

      active_d = (state_d == S_RUN);
   end

   always_ff @(posedge CLK) begin
      if (!RESET_n) begin
         state_q   <= S_IDLE;
         hold_q    <= '0;
         level_q   <= '0;
         acc_q     <= '0;
         div_cnt_q <= '0;
         dac_q     <= 1'b0;
         active_q  <= 1'b0;
      end else begin
         state_q   <= state_d;
         hold_q    <= hold_d;
         level_q   <= level_d;
         acc_q     <= acc_d;
         div_cnt_q <= div_cnt_d;
         dac_q     <= dac_d;
         active_q  <= active_d;
      end
   end

   assign DAC_OUT   = dac_q;
   assign ACTIVE    = active_q;
   assign DBG_STATE = state_q;

endmodule

// File: tb/tb_sound_dac_ds.sv
// tb_sound_dac_ds
//   Drives two instances of sound_dac_ds (DIV=1 and DIV=4) from the same
//   stimulus. A behavioural model computes expected outputs with plain
//   integer arithmetic; one compare process checks every cycle, and the
//   directed sequence adds literal expectations (ramp lengths, ones counts).

module tb_sound_dac_ds;

   localparam int W = 16;

   // clock / reset
   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic          rst_n     = 1'b0;
   logic [W-1:0]  in_data   = '0;
   logic          in_strobe = 1'b0;
   logic          en        = 1'b0;
   logic          mute      = 1'b0;
   logic [1:0]    dac, act;
   logic [1:0]    dbg0, dbg4;

   sound_dac_ds #(.WIDTH(W), .DIV(1), .RAMP_STEP(16)) u_dut1 (
      .CLK(clk), .RESET_n(rst_n), .IN_DATA(in_data), .IN_STROBE(in_strobe),
      .ENABLE(en), .MUTE(mute), .DAC_OUT(dac[0]), .ACTIVE(act[0]),
      .DBG_STATE(dbg0)
   );

   sound_dac_ds #(.WIDTH(W), .DIV(4), .RAMP_STEP(16)) u_dut4 (
      .CLK(clk), .RESET_n(rst_n), .IN_DATA(in_data), .IN_STROBE(in_strobe),
      .ENABLE(en), .MUTE(mute), .DAC_OUT(dac[1]), .ACTIVE(act[1]),
      .DBG_STATE(dbg4)
   );

   // scoreboard
   int n_cmp  = 0;
   int n_fail = 0;
   bit cmp_en = 1'b0;
   logic [3:0] exp_q0[$];
   logic [3:0] exp_q1[$];

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
      n_cmp++;
      if (got !== want) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", name, got, want);
      end
   endtask

   // behavioural model: states 0 IDLE, 1 RAMP_UP, 2 RUN, 3 RAMP_DOWN
   localparam int MIDV = 32768;
   int m_div[2] = '{1, 4};
   int m_state[2], m_hold[2], m_level[2], m_acc[2], m_cnt[2], m_out[2], m_act[2];

   always @(posedge clk) begin
      int u, s;
      bit tk;
      for (int k = 0; k < 2; k++) begin
         if (!rst_n) begin
            m_state[k] = 0; m_hold[k] = 0; m_level[k] = 0; m_acc[k] = 0;
            m_cnt[k] = 0; m_out[k] = 0; m_act[k] = 0;
         end else begin
            tk = (m_cnt[k] == m_div[k] - 1);
            m_cnt[k] = tk ? 0 : m_cnt[k] + 1;
            if (tk) begin
               if (m_state[k] == 2) u = mute ? MIDV : m_hold[k] + MIDV;
               else                 u = m_level[k];
               s = m_acc[k] + u;
               m_out[k] = s / 65536;
               m_acc[k] = s % 65536;
               case (m_state[k])
                  0: begin
                     m_level[k] = 0;
                     if (en) m_state[k] = 1;
                  end
                  1: begin
                     if (!en) m_state[k] = 3;
                     else begin
                        m_level[k] = (m_level[k] + 16 > MIDV) ? MIDV : m_level[k] + 16;
                        if (m_level[k] == MIDV) m_state[k] = 2;
                     end
                  end
                  2: if (!en) m_state[k] = 3;
                  default: begin
                     if (en) m_state[k] = 1;
                     else begin
                        m_level[k] = (m_level[k] - 16 < 0) ? 0 : m_level[k] - 16;
                        if (m_level[k] == 0) m_state[k] = 0;
                     end
                  end
               endcase
            end
            m_act[k] = (m_state[k] == 2);
            if (in_strobe) m_hold[k] = $signed(in_data);
         end
         if (cmp_en) begin
            if (k == 0) exp_q0.push_back({2'(m_state[k]), 1'(m_act[k]), 1'(m_out[k])});
            else        exp_q1.push_back({2'(m_state[k]), 1'(m_act[k]), 1'(m_out[k])});
         end
      end
   end

   // compare process: every cycle, both instances
   always @(negedge clk) begin
      logic [3:0] e;
      if (exp_q0.size() > 0) begin
         e = exp_q0.pop_front();
         check("dac1_out",   dac[0], e[0]);
         check("dac1_active", act[0], e[1]);
         check("dac1_state",  dbg0,  e[3:2]);
      end
      if (exp_q1.size() > 0) begin
         e = exp_q1.pop_front();
         check("dac4_out",    dac[1], e[0]);
         check("dac4_active", act[1], e[1]);
         check("dac4_state",  dbg4,  e[3:2]);
      end
   end

   // driver tasks
   task automatic cycles(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic strobe(input logic [W-1:0] v);
      in_data   = v;
      in_strobe = 1'b1;
      @(negedge clk);
      in_strobe = 1'b0;
   endtask

   task automatic count_ones(input int n, output int ones0, output int ones4);
      ones0 = 0;
      ones4 = 0;
      repeat (n) begin
         @(negedge clk);
         ones0 += int'(dac[0]);
         ones4 += int'(dac[1]);
      end
   endtask

   initial begin
      int c0, c4, o0, o4;
      int win[8];
      logic [W-1:0] vec[4];
      bit first;

      // reset
      cycles(3);
      check("reset_dac1", dac[0], 1'b0);
      check("reset_act1", act[0], 1'b0);
      check("reset_st1",  dbg0,  2'd0);
      check("reset_dac4", dac[1], 1'b0);
      check("reset_st4",  dbg4,  2'd0);
      rst_n  = 1'b1;
      cmp_en = 1'b1;
      cycles(2);

      // ramp up: 2048 ticks in RAMP_UP for both dividers
      en = 1'b1;
      c0 = 0; c4 = 0;
      foreach (win[i]) win[i] = 0;
      for (int i = 0; i < 12000 && !(act[0] && act[1]); i++) begin
         @(negedge clk);
         if (dbg0 == 2'd1) begin
            c0++;
            if (c0 <= 2048) win[(c0 - 1) / 256] += int'(dac[0]);
         end
         if (dbg4 == 2'd1) c4++;
      end
      check("ramp_up_ticks_div1",   c0, 2048);
      check("ramp_up_clocks_div4",  c4, 8192);
      check("active_after_ramp1",   act[0], 1'b1);
      check("active_after_ramp4",   act[1], 1'b1);
      for (int i = 1; i < 8; i++)
         check($sformatf("ramp_window_%0d_nondecr", i), 32'(win[i] >= win[i-1]), 1);

      // midscale audio: 50% ones
      strobe(16'h0000);
      cycles(8);
      count_ones(1024, o0, o4);
      check("mid_ones_div1", o0, 512);
      check("mid_ones_div4", o4, 512);

      // 0x4000: three ones in every four ticks
      strobe(16'h4000);
      cycles(8);
      count_ones(1024, o0, o4);
      check("q3_ones_div1", o0, 768);
      check("q3_ones_div4", o4, 768);

      // most negative: constantly 0
      strobe(16'h8000);
      cycles(8);
      count_ones(256, o0, o4);
      check("neg_full_ones_div1", o0, 0);
      check("neg_full_ones_div4", o4, 0);

      // most positive: at most one zero in 4096 ticks
      strobe(16'h7FFF);
      cycles(8);
      count_ones(4096, o0, o4);
      check("pos_full_ones_div1", 32'(o0 >= 4095), 1);

      // mute: 50% from the very next tick
      mute = 1'b1;
      count_ones(1024, o0, o4);
      check("mute_ones_div1", o0, 512);
      mute = 1'b0;

      // back-to-back strobes between DIV=4 ticks; the model checks which lands
      vec = '{16'h1234, 16'hFEDC, 16'h0001, 16'h8001};
      for (int r = 0; r < 4; r++) begin
         for (int i = 0; i < 4; i++) strobe(vec[(i + r) % 4]);
         cycles($urandom_range(3, 9));
         strobe(vec[r] ^ 16'h0F0F);
         cycles(40);
      end

      // ramp down with mute on: ACTIVE drops on the next tick
      mute = 1'b1;
      en   = 1'b0;
      c0 = 0; c4 = 0; first = 1'b1;
      for (int i = 0; i < 12000 && !(first == 1'b0 && dbg0 == 2'd0 && dbg4 == 2'd0); i++) begin
         @(negedge clk);
         if (first) check("active_drop_div1", act[0], 1'b0);
         first = 1'b0;
         if (dbg0 == 2'd3) c0++;
         if (dbg4 == 2'd3) c4++;
      end
      check("ramp_down_ticks_div1",  c0, 2048);
      check("ramp_down_clocks_div4", c4, 8192);
      mute = 1'b0;
      cycles(8);
      count_ones(100, o0, o4);
      check("idle_silent_div1", o0, 0);
      check("idle_silent_div4", o4, 0);

      // reset in the middle of a ramp, then restart from level 0
      en = 1'b1;
      c0 = 0;
      for (int i = 0; i < 3000 && c0 < 1000; i++) begin
         @(negedge clk);
         if (dbg0 == 2'd1) c0++;
      end
      check("ramp_reached_1000", c0, 1000);
      rst_n = 1'b0;
      @(negedge clk);
      check("midramp_rst_dac1", dac[0], 1'b0);
      check("midramp_rst_act1", act[0], 1'b0);
      check("midramp_rst_st1",  dbg0,  2'd0);
      check("midramp_rst_st4",  dbg4,  2'd0);
      rst_n = 1'b1;
      c0 = 0;
      for (int i = 0; i < 5000 && !act[0]; i++) begin
         @(negedge clk);
         if (dbg0 == 2'd1) c0++;
      end
      check("restart_ramp_ticks_div1", c0, 2048);
      cycles(4);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
